rijndael_inv_shiftrows_stream: RTL and testbench
================================================

// Module: rijndael_inv_shiftrows_stream
// PURPOSE
//   Byte-serial Rijndael InvShiftRows unit for the decryption datapath. Accepts one
//   full state (4*NB bytes) over a valid/ready byte stream and buffers it. It then
//   emits the InvShiftRows-permuted state on a second valid/ready byte stream.
//   Sits between the byte-serial InvSubBytes and AddRoundKey stages of the
//   iterative decryption core.
// PARAMETERS
//   NB      4   state columns; legal 4, 6, 8; any other value -> $error at elaboration
//   NBYTES  4*NB (localparam) bytes per state; byte index k = 4*c + r (column-major)
// PORTS
//   clk_i        in   1  single clock, all logic on rising edge
//   rst_ni       in   1  synchronous reset, active-low
//   in_valid_i   in   1  input byte valid
//   in_ready_o   out  1  unit can accept an input byte
//   in_data_i    in   8  input byte; k=0 first (= MSB byte of flattened state)
//   out_valid_o  out  1  output byte valid
//   out_ready_i  in   1  downstream accepts output byte
//   out_data_o   out  8  permuted byte, k=0 first
//   out_last_o   out  1  high with byte k=NBYTES-1
// BEHAVIOUR
//   - Row shifts: NB=4/6 -> {0,1,2,3}; NB=8 -> {0,1,3,4}.
//   - Inverse map: out[r][c] = in[r][(c - SHIFT_r + NB) % NB].
//   - Transfer occurs only in a cycle with valid && ready, per port.
//   - FSM states:
//     - LOAD: in_ready_o=1, out_valid_o=0. Each transfer writes buf[in_cnt] and
//       increments in_cnt. The transfer at in_cnt=NBYTES-1 sets in_cnt=0 and
//       moves to DRAIN.
//     - DRAIN: in_ready_o=0, out_valid_o=1. out_data_o = buf[src(out_cnt)].
//       Each transfer increments out_cnt. The transfer at out_cnt=NBYTES-1 sets
//       out_cnt=0 and moves to LOAD.
//   - out_data_o/out_last_o are combinational from registered buf/out_cnt.
//   - Output data holds stable while out_valid_o && !out_ready_i.
//   - Latency: first output byte valid the cycle after the last input transfer.
//   - No overlap between LOAD and DRAIN. Min 2*NBYTES cycles per state.
//   - In DRAIN, in_valid_i is ignored and no buffer write occurs.
//   - out_data_o=8'h00 and out_last_o=0 whenever out_valid_o=0.
//   - Counters are ceil(log2(NBYTES)) bits wide, and wrap only via the explicit
//     clear at NBYTES-1.
//   - Source index src is computed in 0..NB-1 space. Never negative modulo:
//     add NB before %.
//   - Reset (rst_ni=0 at edge):
//     - FSM to LOAD, in_cnt=out_cnt=0; buf is not reset.
//     - While rst_ni=0: in_ready_o=0, out_valid_o=0, out_data_o=0, out_last_o=0.
//     - Reset mid-LOAD or mid-DRAIN discards the partial state. No byte of the
//       old state appears afterwards.
// CONFIGURATION
//   RIJNDAEL_SHIFTROWS_DIR_EN defined:
//     - Adds port fwd_i (in, 1), sampled on the k=0 input transfer and held in
//       dir_q for the whole state.
//     - dir_q=1 -> forward map out[r][c] = in[r][(c + SHIFT_r) % NB].
//     - dir_q=0 -> inverse map.
//     - dir_q resets to 0.
//   Not defined: no fwd_i port; inverse map only; no dir_q flop.
// TESTING
//   1. NB=4, in bytes 00..0F, out_ready_i=1 -> out
//      00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03.
//      out_last_o only on 03; first out_valid_o one cycle after the 0F transfer.
//   2. NB=8, in bytes 00..1F -> first four out 00 1D 16 13, last four 1C 19 12 0F.
//   3. NB=4, random out_ready_i (~50%) and gaps on in_valid_i -> same sequence as
//      test 1. out_data_o stable while stalled; in_ready_o=0 throughout DRAIN.
//   4. Reset after 7 input bytes, then feed 00..0F -> output exactly as test 1,
//      with no stale bytes. Reset during DRAIN after 5 outputs: out_valid_o=0
//      next cycle and in_ready_o=1.
//   5. Back-to-back states A then B (00..0F, then 10..1F) -> B output begins
//      10 1D 1A 17 only after A's out_last_o transfer.
//   6. With RIJNDAEL_SHIFTROWS_DIR_EN:
//      - fwd_i=1 on k=0, in 00..0F -> out 00 05 0A 0F 04 09 0E 03 ...
//      - Toggling fwd_i mid-state has no effect.
//      - Forward then inverse pass returns 00..0F.

Source files
------------

// File: rtl/rijndael_inv_shiftrows_stream_if.sv
// Byte-stream handshake bundle for the Rijndael (Inv)ShiftRows stream unit.
// Holds the input byte stream and the output byte stream, each with valid/ready.
interface rijndael_inv_shiftrows_stream_if;
   logic       in_valid_i;
   logic       in_ready_o;
   logic [7:0] in_data_i;
   logic       out_valid_o;
   logic       out_ready_i;
   logic [7:0] out_data_o;
   logic       out_last_o;

   modport slave (
      input  in_valid_i,
      input  in_data_i,
      input  out_ready_i,
      output in_ready_o,
      output out_valid_o,
      output out_data_o,
      output out_last_o
   );

   modport master (
      output in_valid_i,
      output in_data_i,
      output out_ready_i,
      input  in_ready_o,
      input  out_valid_o,
      input  out_data_o,
      input  out_last_o
   );
endinterface

// File: rtl/rijndael_inv_shiftrows_stream.sv
// Byte-serial Rijndael InvShiftRows: buffers one 4*NB-byte state, then streams it permuted.
// Optional RIJNDAEL_SHIFTROWS_DIR_EN adds fwd_i to select the forward ShiftRows map per state.
module rijndael_inv_shiftrows_stream #(
   parameter int unsigned NB = 4
) (
   input logic clk_i,
   input logic rst_ni,
`ifdef RIJNDAEL_SHIFTROWS_DIR_EN
   input logic fwd_i,
`endif
   rijndael_inv_shiftrows_stream_if.slave bus
);

   localparam int unsigned NBYTES = 4 * NB;
   localparam int unsigned CW     = $clog2(NBYTES);
   localparam int unsigned CLW    = CW - 2;
   localparam int unsigned SW     = CLW + 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
      $error("rijndael_inv_shiftrows_stream: NB must be 4, 6 or 8");
   end

   typedef enum logic {ST_LOAD, ST_DRAIN} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] in_cnt_q, in_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [7:0]    mem_q [NBYTES];
   logic [7:0]    mem_d [NBYTES];

   logic          in_ready, out_valid, in_fire, out_fire, dir;
   logic [CLW-1:0] col;
   logic [1:0]    row;
   logic [2:0]    shift;
   logic [SW-1:0] sum, src_col;
   logic [CW-1:0] src;

   // Handshake is gated by reset so nothing is offered or accepted while rst_ni is low.
   assign in_ready  = rst_ni && (state_q == ST_LOAD);
   assign out_valid = rst_ni && (state_q == ST_DRAIN);
   assign in_fire   = in_ready && bus.in_valid_i;
   assign out_fire  = out_valid && bus.out_ready_i;

`ifdef RIJNDAEL_SHIFTROWS_DIR_EN
   logic dir_q, dir_d;

   // Direction is latched with the first byte of a state and held until the next one.
   always_comb begin
      dir_d = dir_q;
      if (in_fire && (in_cnt_q == '0)) dir_d = fwd_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) dir_q <= 1'b0;
      else         dir_q <= dir_d;
   end

   assign dir = dir_q;
`else
   assign dir = 1'b0;
`endif

   // Load/drain sequencing.
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      case (state_q)
         ST_LOAD: begin
            if (in_fire) begin
               if (in_cnt_q == LAST) begin
                  in_cnt_d = '0;
                  state_d  = ST_DRAIN;
               end else begin
                  in_cnt_d = in_cnt_q + CW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (out_fire) begin
               if (out_cnt_q == LAST) begin
                  out_cnt_d = '0;
                  state_d   = ST_LOAD;
               end else begin
                  out_cnt_d = out_cnt_q + CW'(1);
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (in_fire) mem_d[in_cnt_q] = bus.in_data_i;
   end

   // Source byte for the current output position; column offset kept non-negative before modulo.
   always_comb begin
      col   = out_cnt_q[CW-1:2];
      row   = out_cnt_q[1:0];
      case (row)
         2'd0:    shift = 3'd0;
         2'd1:    shift = 3'd1;
         2'd2:    shift = (NB == 8) ? 3'd3 : 3'd2;
         default: shift = (NB == 8) ? 3'd4 : 3'd3;
      endcase
      if (dir) sum = SW'(col) + SW'(shift);
      else     sum = SW'(col) + SW'(NB) - SW'(shift);
      src_col = sum % SW'(NB);
      src     = {src_col[CLW-1:0], row};
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = out_valid ? mem_q[src] : 8'h00;
   assign bus.out_last_o  = out_valid && (out_cnt_q == LAST);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_LOAD;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_rijndael_inv_shiftrows_stream.sv
// Randomized bench for rijndael_inv_shiftrows_stream (NB=4 and NB=8 instances) against a state-matrix model.
// Exercises the forward map too when RIJNDAEL_SHIFTROWS_DIR_EN is defined.
module tb_rijndael_inv_shiftrows_stream;
   typedef logic [7:0] byte_q_t [$];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rijndael_inv_shiftrows_stream_if ifa ();
   rijndael_inv_shiftrows_stream_if ifb ();

`ifdef RIJNDAEL_SHIFTROWS_DIR_EN
   logic fwd_a = 1'b0;
   logic fwd_b = 1'b0;
   localparam bit DIR_EN = 1'b1;
`else
   localparam bit DIR_EN = 1'b0;
`endif

   rijndael_inv_shiftrows_stream #(.NB(4)) dut_a (
      .clk_i  (clk),
      .rst_ni (rst_n),
`ifdef RIJNDAEL_SHIFTROWS_DIR_EN
      .fwd_i  (fwd_a),
`endif
      .bus    (ifa)
   );

   rijndael_inv_shiftrows_stream #(.NB(8)) dut_b (
      .clk_i  (clk),
      .rst_ni (rst_n),
`ifdef RIJNDAEL_SHIFTROWS_DIR_EN
      .fwd_i  (fwd_b),
`endif
      .bus    (ifb)
   );

   int n_chk  = 0;
   int n_pass = 0;

   byte_q_t    in_q;
   bit         in_dir_q [$];
   logic [8:0] exp_q [$];
   int         sent_cnt  = 0;
   int         gap_pct   = 0;
   int         stall_pct = 0;

   logic [7:0] t1 [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                           8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
   logic [7:0] t6 [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                           8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
   logic [7:0] b_head [4] = '{8'h00, 8'h1D, 8'h16, 8'h13};
   logic [7:0] b_tail [4] = '{8'h1C, 8'h19, 8'h12, 8'h0F};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // State as a 4 x nb matrix; each row r is rotated by its shift (right for inverse, left for forward).
   function automatic byte_q_t shiftrows_ref(input int nb, input bit fwd, input byte_q_t st);
      int         sh [4];
      logic [7:0] m [4][8];
      byte_q_t    o;
      sh[0] = 0;
      sh[1] = 1;
      sh[2] = (nb == 8) ? 3 : 2;
      sh[3] = (nb == 8) ? 4 : 3;
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++) m[r][c] = st[4*c + r];
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++)
            o.push_back(m[r][fwd ? (c + sh[r]) % nb : (c - sh[r] + nb) % nb]);
      return o;
   endfunction

   task automatic push_in(input byte_q_t st, input bit fwd);
      foreach (st[i]) begin
         in_q.push_back(st[i]);
         in_dir_q.push_back(fwd);
      end
   endtask

   task automatic push_exp(input byte_q_t o);
      foreach (o[i]) begin
         logic last;
         last = ((i % 16) == 15);
         exp_q.push_back({last, o[i]});
      end
   endtask

   task automatic idle_inputs();
      ifa.in_valid_i  = 1'b0;
      ifa.in_data_i   = 8'h00;
      ifa.out_ready_i = 1'b0;
      ifb.in_valid_i  = 1'b0;
      ifb.in_data_i   = 8'h00;
      ifb.out_ready_i = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      @(posedge clk);
      @(negedge clk);
      check("rst_a_in_ready",  32'(ifa.in_ready_o), 32'd0);
      check("rst_a_out_valid", 32'(ifa.out_valid_o), 32'd0);
      check("rst_a_out",       32'({ifa.out_last_o, ifa.out_data_o}), 32'd0);
      check("rst_b_in_ready",  32'(ifb.in_ready_o), 32'd0);
      check("rst_b_out_valid", 32'(ifb.out_valid_o), 32'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready",  32'(ifa.in_ready_o), 32'd1);
      check("post_rst_out_valid", 32'(ifa.out_valid_o), 32'd0);
      in_q.delete();
      in_dir_q.delete();
      exp_q.delete();
      sent_cnt = 0;
   endtask

   // Drives instance A from in_q and scores its output against exp_q, one cycle per negedge.
   task automatic run(input int max_out);
      int         outs = 0;
      int         cyc  = 0;
      bit         prev_stall = 1'b0;
      bit         first_pending = 1'b0;
      bit         rdy, fwd_v;
      logic [7:0] prev_data = 8'h00;
      logic [8:0] e;
      while ((in_q.size() != 0 || exp_q.size() != 0) && outs < max_out && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (first_pending) begin
            check("latency", 32'(ifa.out_valid_o), 32'd1);
            first_pending = 1'b0;
         end
         if (ifa.out_valid_o) begin
            check("in_ready_drain", 32'(ifa.in_ready_o), 32'd0);
            if (prev_stall) check("stall_hold", 32'(ifa.out_data_o), 32'(prev_data));
         end else begin
            check("in_ready_load", 32'(ifa.in_ready_o), 32'd1);
            check("idle_out", 32'({ifa.out_last_o, ifa.out_data_o}), 32'd0);
         end
         rdy = ($urandom_range(99) >= 32'(stall_pct));
         ifa.out_ready_i = rdy;
         if (ifa.out_valid_o && rdy) begin
            if (exp_q.size() == 0) begin
               check("extra_out", 32'({ifa.out_last_o, ifa.out_data_o}), 32'h1FF);
            end else begin
               e = exp_q.pop_front();
               check("out_byte", 32'({ifa.out_last_o, ifa.out_data_o}), 32'(e));
            end
            outs++;
         end
         prev_stall = ifa.out_valid_o && !rdy;
         prev_data  = ifa.out_data_o;
         if (in_q.size() != 0 && $urandom_range(99) >= 32'(gap_pct)) begin
            ifa.in_valid_i = 1'b1;
            ifa.in_data_i  = in_q[0];
            fwd_v = (sent_cnt == 0) ? in_dir_q[0] : 1'($urandom);
         end else begin
            ifa.in_valid_i = 1'b0;
            ifa.in_data_i  = 8'($urandom);
            fwd_v = 1'($urandom);
         end
`ifdef RIJNDAEL_SHIFTROWS_DIR_EN
         fwd_a = fwd_v;
`endif
         if (ifa.in_valid_i && ifa.in_ready_o) begin
            void'(in_q.pop_front());
            void'(in_dir_q.pop_front());
            sent_cnt = (sent_cnt == 15) ? 0 : sent_cnt + 1;
            if (sent_cnt == 0) first_pending = 1'b1;
         end
      end
      if (cyc >= 4000) check("timeout", 32'(cyc), 32'd0);
      @(negedge clk);
      ifa.in_valid_i  = 1'b0;
      ifa.out_ready_i = 1'b0;
   endtask

   initial begin
      byte_q_t    st, st2, tq, st8, o8;
      logic [8:0] got [$];
      int         bc;
      bit         fwd;

      idle_inputs();
      apply_reset();

      // In-order state 00..0F, no gaps or stalls.
      st = {};
      for (int i = 0; i < 16; i++) st.push_back(8'(i));
      tq = {};
      foreach (t1[i]) tq.push_back(t1[i]);
      gap_pct = 0; stall_pct = 0;
      push_in(st, 1'b0); push_exp(tq); run(1 << 30);

      // Same state with input gaps and output stalls.
      gap_pct = 40; stall_pct = 50;
      push_in(st, 1'b0); push_exp(tq); run(1 << 30);

      // Reset after a partial load, then a clean state.
      gap_pct = 0; stall_pct = 0;
      st2 = {};
      for (int i = 0; i < 7; i++) st2.push_back(8'($urandom));
      push_in(st2, 1'b0); run(1 << 30);
      apply_reset();
      push_in(st, 1'b0); push_exp(tq); run(1 << 30);

      // Reset after five drained bytes, then a fresh random state.
      st2 = {};
      for (int i = 0; i < 16; i++) st2.push_back(8'($urandom));
      push_in(st2, 1'b0); push_exp(shiftrows_ref(4, 1'b0, st2)); run(5);
      apply_reset();
      st2 = {};
      for (int i = 0; i < 16; i++) st2.push_back(8'($urandom));
      gap_pct = 20; stall_pct = 30;
      push_in(st2, 1'b0); push_exp(shiftrows_ref(4, 1'b0, st2)); run(1 << 30);

      // Back-to-back states 00..0F then 10..1F.
      gap_pct = 0; stall_pct = 0;
      st2 = {};
      for (int i = 16; i < 32; i++) st2.push_back(8'(i));
      push_in(st, 1'b0); push_exp(tq);
      push_in(st2, 1'b0); push_exp(shiftrows_ref(4, 1'b0, st2));
      run(1 << 30);

      // Random states, random handshake timing and (if available) random direction.
      gap_pct = 30; stall_pct = 40;
      for (int s = 0; s < 20; s++) begin
         st2 = {};
         for (int i = 0; i < 16; i++) st2.push_back(8'($urandom));
         fwd = DIR_EN ? 1'($urandom) : 1'b0;
         push_in(st2, fwd); push_exp(shiftrows_ref(4, fwd, st2));
      end
      run(1 << 30);

`ifdef RIJNDAEL_SHIFTROWS_DIR_EN
      // Forward map of 00..0F, then inverse of that result returns 00..0F.
      gap_pct = 25; stall_pct = 25;
      tq = {};
      foreach (t6[i]) tq.push_back(t6[i]);
      push_in(st, 1'b1); push_exp(tq);
      push_in(tq, 1'b0); push_exp(st);
      run(1 << 30);
`endif

      // NB=8 instance: 00..1F straight through.
      st8 = {};
      for (int i = 0; i < 32; i++) st8.push_back(8'(i));
      o8 = shiftrows_ref(8, 1'b0, st8);
      ifb.out_ready_i = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         check("b_in_ready", 32'(ifb.in_ready_o), 32'd1);
         ifb.in_valid_i = 1'b1;
         ifb.in_data_i  = st8[i];
      end
      @(negedge clk);
      ifb.in_valid_i = 1'b0;
      check("b_latency", 32'(ifb.out_valid_o), 32'd1);
      got = {};
      bc  = 0;
      while (got.size() < 32 && bc < 200) begin
         if (ifb.out_valid_o) got.push_back({ifb.out_last_o, ifb.out_data_o});
         bc++;
         if (got.size() < 32) @(negedge clk);
      end
      ifb.out_ready_i = 1'b0;
      check("b_count", 32'(got.size()), 32'd32);
      foreach (got[i]) begin
         logic last;
         last = (i == 31);
         check("b_out", 32'(got[i]), 32'({last, o8[i]}));
      end
      if (got.size() == 32) begin
         for (int i = 0; i < 4; i++) begin
            check("b_head", 32'(got[i][7:0]), 32'(b_head[i]));
            check("b_tail", 32'(got[28 + i][7:0]), 32'(b_tail[i]));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
